// File: rtl/reg_writeback_queue.sv
// Writeback queue between MEM and the register-file write port, with
// youngest-first forwarding of pending writes to two reader queries.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_mem,
  input  logic        stall_wb,
  input  logic        flush,
  output logic [4:0]  RegWrite,
  output logic [31:0] DataWrite,
  output logic        WriteEnable,
  input  logic [4:0]  fwd_addr1,
  input  logic [4:0]  fwd_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic [3:0]  count,
  output logic [31:0] retired
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [4:0]       r_rd    [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [3:0]       r_count;
  logic             r_we;
  logic [4:0]       r_wrd;
  logic [31:0]      r_wdata;
  logic [31:0]      r_retired;

  logic             w_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_in_data;
  logic [PW-1:0]    w_ord   [DEPTH];
  logic [4:0]       w_qaddr [2];
  logic             w_hit   [2];
  logic [31:0]      w_fdata [2];

  assign w_ready   = !RESET && (r_count < DEPTH_C) && !flush;
  assign w_accept  = in_valid && w_ready;
  // Writes to r0 are accepted from the producer but never occupy a slot.
  assign w_push    = w_accept && (in_rd != 5'd0);
  assign w_pop     = (r_count != 4'd0) && !stall_wb && !flush;
  assign w_in_data = in_sel ? in_mem : in_alu;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_wrd     <= '0;
      r_wdata   <= '0;
      r_retired <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_we            <= 1'b1;
        r_wrd           <= r_rd[r_head];
        r_wdata         <= r_data[r_head];
        r_retired       <= r_retired + 32'd1;
      end else begin
        r_we <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; validity is tracked by r_valid.
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= w_in_data;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_ord[k] = r_head + PW'(k);
    end
  end

  assign w_qaddr[0] = fwd_addr1;
  assign w_qaddr[1] = fwd_addr2;

  // Scan oldest to youngest so the youngest matching entry wins;
  // the write-port register only matters when no queue entry matches.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_hit[p]   = 1'b0;
      w_fdata[p] = '0;
      if (w_qaddr[p] != 5'd0) begin
        if (r_we && (r_wrd == w_qaddr[p])) begin
          w_hit[p]   = 1'b1;
          w_fdata[p] = r_wdata;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (r_valid[w_ord[k]] && (r_rd[w_ord[k]] == w_qaddr[p])) begin
            w_hit[p]   = 1'b1;
            w_fdata[p] = r_data[w_ord[k]];
          end
        end
      end
    end
  end

  assign in_ready    = w_ready;
  assign RegWrite    = r_wrd;
  assign DataWrite   = r_wdata;
  assign WriteEnable = r_we;
  assign count       = r_count;
  assign retired     = r_retired;
  assign fwd_hit1    = w_hit[0];
  assign fwd_hit2    = w_hit[1];
  assign fwd_data1   = w_fdata[0];
  assign fwd_data2   = w_fdata[1];

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench: stimulus pushes expected writes into a scoreboard, a
// negedge monitor pops and compares every write-port pulse.
module tb_reg_writeback_queue;

  logic        CLOCK;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_sel;
  logic [31:0] in_alu;
  logic [31:0] in_mem;
  logic        stall_wb;
  logic        flush;
  logic [4:0]  RegWrite;
  logic [31:0] DataWrite;
  logic        WriteEnable;
  logic [4:0]  fwd_addr1;
  logic [4:0]  fwd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [3:0]  count;
  logic [31:0] retired;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
    .stall_wb(stall_wb), .flush(flush), .RegWrite(RegWrite),
    .DataWrite(DataWrite), .WriteEnable(WriteEnable),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .retired(retired)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push_one(input logic [4:0] rd, input logic sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] expd, input bit store);
    exp_t e;
    in_valid = 1'b1;
    in_rd    = rd;
    in_sel   = sel;
    in_alu   = alu;
    in_mem   = mem;
    if (store) begin
      e.rd   = rd;
      e.data = expd;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every write-port pulse must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      if (WriteEnable === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual=rd%0d/%h required=no write", RegWrite, DataWrite);
        end else begin
          e = sb.pop_front();
          chk("wr_rd", 32'(RegWrite), 32'(e.rd));
          chk("wr_data", DataWrite, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; in_valid = 1'b1; in_rd = 5'd3; in_sel = 1'b0;
    in_alu = 32'h0000_1234; in_mem = '0; stall_wb = 1'b0; flush = 1'b0;
    fwd_addr1 = 5'd3; fwd_addr2 = 5'd0;

    // Reset state, no accept while RESET is high
    #2;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(WriteEnable), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_datawrite", DataWrite, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit1), 32'd0);
    tick(); tick();
    chk("rst_no_accept", 32'(count), 32'd0);
    in_valid = 1'b0; RESET = 1'b0; fwd_addr1 = 5'd0;
    tick();

    // Single write and latency
    push_one(5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1);
    chk("single_count", 32'(count), 32'd1);
    chk("single_we_early", 32'(WriteEnable), 32'd0);
    fwd_addr1 = 5'd5; #1;
    chk("single_fwdq_hit", 32'(fwd_hit1), 32'd1);
    chk("single_fwdq_data", fwd_data1, 32'hDEAD_BEEF);
    tick();
    chk("single_we", 32'(WriteEnable), 32'd1);
    chk("single_rd", 32'(RegWrite), 32'd5);
    chk("single_data", DataWrite, 32'hDEAD_BEEF);
    chk("single_retired", retired, 32'd1);
    chk("single_count0", 32'(count), 32'd0);
    chk("single_fwdp_hit", 32'(fwd_hit1), 32'd1);
    tick();
    chk("single_we_off", 32'(WriteEnable), 32'd0);
    chk("single_rd_hold", 32'(RegWrite), 32'd5);
    chk("single_fwd_off", 32'(fwd_hit1), 32'd0);
    chk("single_fwd_data0", fwd_data1, 32'd0);

    // Fill under stall, reject when full, then drain
    stall_wb = 1'b1;
    push_one(5'd1, 1'b1, 32'hA000_0001, 32'hB000_0001, 32'hB000_0001, 1);
    push_one(5'd2, 1'b0, 32'hA000_0002, 32'hB000_0002, 32'hA000_0002, 1);
    push_one(5'd3, 1'b1, 32'hA000_0003, 32'hB000_0003, 32'hB000_0003, 1);
    push_one(5'd4, 1'b0, 32'hA000_0004, 32'hB000_0004, 32'hA000_0004, 1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_rd = 5'd9; in_alu = 32'h0000_CCCC; in_sel = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("full_reject", 32'(count), 32'd4);
    stall_wb = 1'b0; #1;
    chk("full_pop_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_we", 32'(WriteEnable), 32'd1);
      chk("drain_rd", 32'(RegWrite), 32'(i));
      chk("drain_count", 32'(count), 32'(4 - i));
    end
    tick();
    chk("drain_we_off", 32'(WriteEnable), 32'd0);
    chk("drain_retired", retired, 32'd5);

    // Simultaneous accept and pop
    stall_wb = 1'b1;
    push_one(5'd10, 1'b0, 32'h0000_00A0, 32'h0, 32'h0000_00A0, 1);
    stall_wb = 1'b0;
    push_one(5'd11, 1'b1, 32'h0, 32'h0000_00B0, 32'h0000_00B0, 1);
    chk("simul_count", 32'(count), 32'd1);
    chk("simul_rd_first", 32'(RegWrite), 32'd10);
    tick();
    chk("simul_rd_second", 32'(RegWrite), 32'd11);
    chk("simul_count0", 32'(count), 32'd0);
    tick();
    chk("simul_retired", retired, 32'd7);

    // Forwarding priority
    stall_wb = 1'b1;
    push_one(5'd7, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_0011, 1);
    push_one(5'd7, 1'b1, 32'h0, 32'h0000_0022, 32'h0000_0022, 1);
    push_one(5'd8, 1'b0, 32'h0000_0033, 32'h0, 32'h0000_0033, 1);
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd0; #1;
    chk("fwd_young_hit", 32'(fwd_hit1), 32'd1);
    chk("fwd_young_data", fwd_data1, 32'h0000_0022);
    chk("fwd_zero_hit", 32'(fwd_hit2), 32'd0);
    chk("fwd_zero_data", fwd_data2, 32'd0);
    fwd_addr2 = 5'd8; #1;
    chk("fwd_rd8_data", fwd_data2, 32'h0000_0033);
    fwd_addr2 = 5'd9; #1;
    chk("fwd_miss_hit", 32'(fwd_hit2), 32'd0);
    chk("fwd_miss_data", fwd_data2, 32'd0);
    stall_wb = 1'b0; fwd_addr2 = 5'd8;
    tick();
    chk("fwd_q_over_port", fwd_data1, 32'h0000_0022);
    tick();
    chk("fwd_port_hit", 32'(fwd_hit1), 32'd1);
    chk("fwd_port_data", fwd_data1, 32'h0000_0022);
    chk("fwd_rd8_queue", fwd_data2, 32'h0000_0033);
    tick();
    chk("fwd_gone_hit", 32'(fwd_hit1), 32'd0);
    chk("fwd_gone_data", fwd_data1, 32'd0);
    chk("fwd_rd8_port", 32'(fwd_hit2), 32'd1);
    tick();
    chk("fwd_after_hit", 32'(fwd_hit2), 32'd0);
    chk("fwd_retired", retired, 32'd10);

    // Zero register is consumed without storing
    fwd_addr1 = 5'd0; fwd_addr2 = 5'd0;
    push_one(5'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 0);
    chk("zero_count", 32'(count), 32'd0);
    tick();
    chk("zero_we", 32'(WriteEnable), 32'd0);
    chk("zero_retired", retired, 32'd10);

    // Flush discards queued entries
    stall_wb = 1'b1;
    push_one(5'd12, 1'b0, 32'h0000_00C1, 32'h0, 32'h0000_00C1, 1);
    push_one(5'd13, 1'b0, 32'h0000_00C2, 32'h0, 32'h0000_00C2, 1);
    push_one(5'd14, 1'b0, 32'h0000_00C3, 32'h0, 32'h0000_00C3, 1);
    chk("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd15; in_alu = 32'h0000_000F;
    stall_wb = 1'b0; #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    tick();
    sb.delete();
    flush = 1'b0; in_valid = 1'b0; fwd_addr1 = 5'd13; #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_we", 32'(WriteEnable), 32'd0);
    chk("flush_fwd", 32'(fwd_hit1), 32'd0);
    chk("flush_ready_back", 32'(in_ready), 32'd1);
    tick(); tick();
    chk("flush_no_write", 32'(WriteEnable), 32'd0);
    chk("flush_retired", retired, 32'd10);
    push_one(5'd20, 1'b0, 32'h0000_0055, 32'h0, 32'h0000_0055, 1);
    tick();
    chk("postflush_we", 32'(WriteEnable), 32'd1);
    chk("postflush_retired", retired, 32'd11);

    // Asynchronous reset mid-queue
    stall_wb = 1'b1; fwd_addr1 = 5'd0;
    push_one(5'd21, 1'b0, 32'h0000_00D1, 32'h0, 32'h0000_00D1, 1);
    push_one(5'd22, 1'b0, 32'h0000_00D2, 32'h0, 32'h0000_00D2, 1);
    push_one(5'd23, 1'b0, 32'h0000_00D3, 32'h0, 32'h0000_00D3, 1);
    stall_wb = 1'b0;
    tick();
    chk("prerst_we", 32'(WriteEnable), 32'd1);
    chk("prerst_retired", retired, 32'd12);
    chk("prerst_count", 32'(count), 32'd2);
    stall_wb = 1'b1; RESET = 1'b1; sb.delete(); fwd_addr1 = 5'd22;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_we", 32'(WriteEnable), 32'd0);
    chk("arst_regwrite", 32'(RegWrite), 32'd0);
    chk("arst_datawrite", DataWrite, 32'd0);
    chk("arst_retired", retired, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_fwd_hit", 32'(fwd_hit1), 32'd0);
    chk("arst_fwd_data", fwd_data1, 32'd0);
    tick();
    RESET = 1'b0; stall_wb = 1'b0;
    tick();
    chk("postrst_we", 32'(WriteEnable), 32'd0);
    chk("postrst_count", 32'(count), 32'd0);
    push_one(5'd25, 1'b0, 32'h0000_0077, 32'h0, 32'h0000_0077, 1);
    tick();
    chk("recover_we", 32'(WriteEnable), 32'd1);
    chk("recover_retired", retired, 32'd1);
    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
